// File: rtl/demux_router_pkg.sv
// Shared definitions for the registered 1-to-N demultiplexer: sizing helpers,
// drop-counter width and the per-lane state encoding.
package demux_router_pkg;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // A single-lane router still needs one select bit.
  function automatic int sel_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry output slot: holds a word until its consumer takes it, and accepts
// a new word in the same cycle that the held one drains.
module demux_lane
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_accept
);

  lane_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    out_valid  = (state_q == LANE_FULL);
    can_accept = !out_valid || out_ready;
    out_data   = out_valid ? data_q : '0;
    case (state_q)
      LANE_EMPTY: begin
        if (load) begin
          state_d = LANE_FULL;
          data_d  = load_data;
        end
      end
      LANE_FULL: begin
        // The owner only loads when can_accept is high, so a load here is
        // always paired with a drain and simply replaces the word.
        if (load) begin
          data_d = load_data;
        end else if (out_ready) begin
          state_d = LANE_EMPTY;
        end
      end
      default: state_d = LANE_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LANE_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-CHANNELS demultiplexer with unicast, broadcast and a
// saturating counter for words addressed to a lane that does not exist.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [sel_width(CHANNELS)-1:0] in_sel,
  input  logic                           in_bcast,
  output logic                           in_ready,
  output logic [CHANNELS-1:0]            out_valid,
  output logic [CHANNELS*WIDTH-1:0]      out_data,
  input  logic [CHANNELS-1:0]            out_ready,
  output logic [DROP_W-1:0]              drop_count
);

  // Handshake: a word moves when valid && ready on the same rising edge, on
  // the input side and on every lane. in_ready never looks at in_valid.

  logic [CHANNELS-1:0] can_accept;
  logic [CHANNELS-1:0] load;
  logic                sel_in_range;
  logic                sel_accept;
  logic                in_fire;
  logic                drop;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;

  always_comb begin
    sel_in_range = (int'(in_sel) < CHANNELS);
    sel_accept   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(in_sel) == i) sel_accept = can_accept[i];
    end

    if (in_bcast) begin
      in_ready = &can_accept;
    end else if (sel_in_range) begin
      in_ready = sel_accept;
    end else begin
      in_ready = 1'b1;
    end

    in_fire = in_valid && in_ready;
    load    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = in_fire && (in_bcast || (int'(in_sel) == i));
    end

    drop         = in_fire && !in_bcast && !sel_in_range;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != DROP_MAX)) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    demux_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (load[g]),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g*WIDTH +: WIDTH]),
      .can_accept(can_accept[g])
    );
  end

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: per-lane expected queues filled by the
// driver, drained and compared by an independent monitor.
module tb_demux_router;
  import demux_router_pkg::*;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 5;
  localparam int SEL_W    = sel_width(CHANNELS);

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      in_valid = 1'b0;
  logic [WIDTH-1:0]          in_data = '0;
  logic [SEL_W-1:0]          in_sel = '0;
  logic                      in_bcast = 1'b0;
  logic                      in_ready;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_ready = '0;
  logic [DROP_W-1:0]         drop_count;

  always #5 clk = ~clk;

  demux_router #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .drop_count(drop_count)
  );

  // Reference model: words each lane still owes its consumer, plus drops.
  logic [WIDTH-1:0] exp_q [CHANNELS][$];
  int               exp_drop = 0;
  int               n_tests = 0;
  int               n_fail = 0;
  bit               mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: presents one cycle of stimulus and records what the block owes.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s,
                       input logic b, input logic [CHANNELS-1:0] r, input logic rst);
    bit all_free;
    bit exp_ready;
    @(negedge clk);
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_bcast  = b;
    out_ready = r;
    #2;
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) exp_q[i].delete();
      exp_drop = 0;
    end else begin
      // The monitor has already retired this cycle's drains, so an empty
      // queue means the lane can take a word now.
      all_free = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (exp_q[i].size() != 0) all_free = 1'b0;
      end
      if (b) exp_ready = all_free;
      else if (int'(s) >= CHANNELS) exp_ready = 1'b1;
      else exp_ready = (exp_q[int'(s)].size() == 0);
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
      if (v && exp_ready) begin
        if (b) begin
          for (int i = 0; i < CHANNELS; i++) exp_q[i].push_back(d);
        end else if (int'(s) >= CHANNELS) begin
          if (exp_drop < 255) exp_drop++;
        end else begin
          exp_q[int'(s)].push_back(d);
        end
      end
    end
  endtask

  // Monitor: compares each lane against the head of its expected queue.
  initial begin
    bit exp_v;
    logic [WIDTH-1:0] exp_d;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        for (int i = 0; i < CHANNELS; i++) begin
          exp_v = (exp_q[i].size() != 0);
          exp_d = exp_v ? exp_q[i][0] : '0;
          check($sformatf("out_valid[%0d]", i), {63'd0, out_valid[i]}, {63'd0, exp_v});
          check($sformatf("out_data[%0d]", i), {56'd0, out_data[i*WIDTH +: WIDTH]}, {56'd0, exp_d});
          if (exp_v && out_ready[i]) void'(exp_q[i].pop_front());
        end
        check("drop_count", {56'd0, drop_count}, 64'(exp_drop));
      end
    end
  end

  initial begin
    logic [SEL_W-1:0] s;
    // Reset held two cycles with a live input that must be ignored.
    cycle(1'b1, 8'h77, 3'd1, 1'b0, '0, 1'b1);
    mon_en = 1'b1;
    cycle(1'b1, 8'h66, 3'd6, 1'b0, '0, 1'b1);

    // Unicast to lane 2 with stalled consumers, then a pass-through drain.
    cycle(1'b1, 8'hA5, 3'd2, 1'b0, 5'b00000, 1'b0);
    for (int n = 0; n < 3; n++) cycle(1'b1, 8'h5A, 3'd2, 1'b0, 5'b00000, 1'b0);
    cycle(1'b1, 8'h5A, 3'd2, 1'b0, 5'b00100, 1'b0);
    cycle(1'b0, 8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);
    cycle(1'b0, 8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);

    // Broadcast into empty lanes, then broadcast blocked by lane 0.
    cycle(1'b1, 8'h3C, 3'd4, 1'b1, 5'b00000, 1'b0);
    for (int n = 0; n < 3; n++) cycle(1'b1, 8'h11, 3'd0, 1'b1, 5'b11110, 1'b0);
    cycle(1'b1, 8'h11, 3'd0, 1'b1, 5'b11111, 1'b0);
    cycle(1'b0, 8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);

    // Out-of-range selects: a few drops, then enough to saturate.
    for (int n = 0; n < 3; n++) cycle(1'b1, 8'hE0, 3'd5, 1'b0, 5'b00000, 1'b0);
    for (int n = 0; n < 260; n++) begin
      s = SEL_W'(5 + (n % 3));
      cycle(1'b1, WIDTH'(n), s, 1'b0, 5'b00000, 1'b0);
    end

    // Full throughput round-robin across the lanes.
    for (int n = 0; n < 16; n++) begin
      s = SEL_W'(n % CHANNELS);
      cycle(1'b1, WIDTH'(8'h80 + n), s, 1'b0, 5'b11111, 1'b0);
    end

    // Reset while lanes 1 and 3 are full, with a word offered to lane 0.
    cycle(1'b1, 8'hB1, 3'd1, 1'b0, 5'b00000, 1'b0);
    cycle(1'b1, 8'hB3, 3'd3, 1'b0, 5'b00000, 1'b0);
    cycle(1'b1, 8'hB0, 3'd0, 1'b0, 5'b00000, 1'b1);
    cycle(1'b1, 8'hC7, 3'd7, 1'b0, 5'b00000, 1'b0);

    // Randomised traffic with occasional resets and varied back-pressure.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 3) != 0, WIDTH'($urandom), SEL_W'($urandom_range(0, 7)),
            $urandom_range(0, 7) == 0, CHANNELS'($urandom | (n[8] ? $urandom : 32'd0)),
            $urandom_range(0, 199) == 0);
    end

    for (int n = 0; n < 4; n++) cycle(1'b0, 8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);
    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
